// File: rtl/booth_seq_mac.sv
// Sequential radix-4 Booth multiply-accumulate: retires one multiplier digit per
// clock into a wide signed accumulator, with add/subtract mode, clear and sticky overflow.
module booth_seq_mac #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             msub,
    input  logic             clr_acc,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);

    localparam int N    = (WIDTH + 1) / 2;
    localparam int YW   = 2 * N + 1;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, next_state;

    logic [ACC_W-1:0] x_sh;      // sign-extended multiplicand, pre-shifted by 2i
    logic [YW-1:0]    y_sh;      // {y sign-extended to 2N, y[-1]}, shifted right by 2 per digit
    logic [CW-1:0]    cnt;
    logic             sub_mode;

    logic             accept;
    logic [2:0]       trip;
    logic             sel_zero, sel_two, sel_neg;
    logic [ACC_W-1:0] mag, pp, sum;
    logic             add_ovf;

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (cnt == LAST) next_state = DONE;
            DONE:    next_state = accept ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Booth digit decode; msub flips the sign of every digit.
    always_comb begin
        trip     = y_sh[2:0];
        sel_zero = 1'b0;
        sel_two  = 1'b0;
        sel_neg  = 1'b0;
        case (trip)
            3'b001, 3'b010: ;
            3'b011:         sel_two = 1'b1;
            3'b100:         begin sel_two = 1'b1; sel_neg = 1'b1; end
            3'b101, 3'b110: sel_neg = 1'b1;
            default:        sel_zero = 1'b1;
        endcase
        sel_neg = sel_neg ^ sub_mode;
        mag     = sel_two ? (x_sh << 1) : x_sh;
        if (sel_zero)     pp = '0;
        else if (sel_neg) pp = '0 - mag;
        else              pp = mag;
        sum     = acc_out + pp;
        add_ovf = (acc_out[ACC_W-1] == pp[ACC_W-1]) && (sum[ACC_W-1] != acc_out[ACC_W-1]);
    end

    // NOTE: operand registers carry no reset; they are always reloaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            x_sh     <= ACC_W'(signed'(x_in));
            y_sh     <= {(2 * N)'(signed'(y_in)), 1'b0};
            sub_mode <= msub;
        end else if (state == RUN) begin
            x_sh <= x_sh << 2;
            y_sh <= y_sh >> 2;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_out <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            cnt <= '0;
            if (clr_acc) begin
                acc_out <= '0;
                ovf     <= 1'b0;
            end
        end else if (state == RUN) begin
            acc_out <= sum;
            ovf     <= ovf | add_ovf;
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_booth_seq_mac.sv
// Directed bench for booth_seq_mac: a 16x16/40 instance for the main function and
// control corners, plus a 5x5/10 instance for the odd-width case.
module tb_booth_seq_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, msub_a, clr_a;
    logic [15:0] x_a, y_a;
    logic        busy_a, done_a, ovf_a;
    logic [39:0] acc_a;
    logic        start_b, msub_b, clr_b;
    logic [4:0]  x_b, y_b;
    logic        busy_b, done_b, ovf_b;
    logic [9:0]  acc_b;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    booth_seq_mac #(.WIDTH(16), .ACC_W(40)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .msub(msub_a), .clr_acc(clr_a),
        .x_in(x_a), .y_in(y_a), .busy(busy_a), .done(done_a), .acc_out(acc_a), .ovf(ovf_a)
    );

    booth_seq_mac #(.WIDTH(5), .ACC_W(10)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .msub(msub_b), .clr_acc(clr_b),
        .x_in(x_b), .y_in(y_b), .busy(busy_b), .done(done_b), .acc_out(acc_b), .ovf(ovf_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on instance A from the current cycle and wait (bounded) for done.
    task automatic run_a(input logic clr, input logic sub, input logic [15:0] x,
                         input logic [15:0] y, output int lat, output int busy_n);
        clr_a = clr; msub_a = sub; x_a = x; y_a = y; start_a = 1'b1;
        tick();
        start_a = 1'b0; x_a = 16'hdead; y_a = 16'hbeef; msub_a = ~sub; clr_a = ~clr;
        lat = -1; busy_n = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy_a) busy_n++;
            tick();
            if (done_a) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tests_run++;
        if ({acc_a, ovf_a, busy_a, done_a} !== 43'd0) begin
            failed++;
            $display("FAIL reset_state: acc=%h ovf=%b busy=%b done=%b want all zero", acc_a, ovf_a, busy_a, done_a);
        end
        tests_run++;
        if ({acc_b, ovf_b, busy_b, done_b} !== 13'd0) begin
            failed++;
            $display("FAIL reset_state_b: acc=%h ovf=%b busy=%b done=%b want all zero", acc_b, ovf_b, busy_b, done_b);
        end
    endtask

    task automatic test_basic();
        int lat, bn;
        run_a(1'b1, 1'b0, 16'd3, 16'd5, lat, bn);
        tests_run++;
        if (lat !== 8) begin failed++; $display("FAIL basic_latency: got %0d want 8", lat); end
        tests_run++;
        if (bn !== 8) begin failed++; $display("FAIL basic_busy_cycles: got %0d want 8", bn); end
        tests_run++;
        if (acc_a !== 40'd15 || ovf_a !== 1'b0) begin
            failed++; $display("FAIL basic_acc: got %0d ovf=%b want 15 ovf=0", $signed(acc_a), ovf_a);
        end
        tests_run++;
        if (busy_a !== 1'b0) begin failed++; $display("FAIL basic_busy_at_done: got %b want 0", busy_a); end
        tick();
        tests_run++;
        if (done_a !== 1'b0 || acc_a !== 40'd15) begin
            failed++; $display("FAIL basic_hold: done=%b acc=%0d want done=0 acc=15", done_a, $signed(acc_a));
        end
    endtask

    task automatic test_msub_back_to_back();
        int lat, bn;
        run_a(1'b0, 1'b1, -16'sd4, 16'd7, lat, bn);
        tests_run++;
        if (acc_a !== 40'd43) begin failed++; $display("FAIL msub_acc: got %0d want 43", $signed(acc_a)); end
        // accept in the DONE cycle: done-to-done gap is one accept edge plus 8 RUN edges
        run_a(1'b0, 1'b0, 16'hffff, 16'hffff, lat, bn);
        tests_run++;
        if (lat + 1 !== 9) begin failed++; $display("FAIL b2b_gap: got %0d want 9", lat + 1); end
        tests_run++;
        if (acc_a !== 40'd44) begin failed++; $display("FAIL b2b_acc: got %0d want 44", $signed(acc_a)); end
    endtask

    task automatic test_extremes();
        int lat, bn;
        logic [39:0] exp_neg;
        exp_neg = -40'sd1073709056;
        tick();
        run_a(1'b1, 1'b0, 16'h8000, 16'h8000, lat, bn);
        tests_run++;
        if (acc_a !== 40'h0040000000 || ovf_a !== 1'b0) begin
            failed++; $display("FAIL min_times_min: got %h ovf=%b want 0040000000 ovf=0", acc_a, ovf_a);
        end
        run_a(1'b1, 1'b0, 16'h7fff, 16'h8000, lat, bn);
        tests_run++;
        if (acc_a !== exp_neg) begin failed++; $display("FAIL max_times_min: got %h want %h", acc_a, exp_neg); end
    endtask

    task automatic test_overflow();
        int lat, bn;
        int bad_lat = 0;
        for (int k = 0; k < 511; k++) begin
            run_a(k == 0, 1'b0, 16'h8000, 16'h8000, lat, bn);
            if (lat != 8) bad_lat++;
        end
        tests_run++;
        if (acc_a !== 40'h7fc0000000 || ovf_a !== 1'b0 || bad_lat != 0) begin
            failed++; $display("FAIL ovf_511: got %h ovf=%b bad_lat=%0d want 7fc0000000 ovf=0 bad_lat=0", acc_a, ovf_a, bad_lat);
        end
        run_a(1'b0, 1'b0, 16'h8000, 16'h8000, lat, bn);
        tests_run++;
        if (acc_a !== 40'h8000000000 || ovf_a !== 1'b1) begin
            failed++; $display("FAIL ovf_512: got %h ovf=%b want 8000000000 ovf=1", acc_a, ovf_a);
        end
        run_a(1'b0, 1'b0, 16'd0, 16'd0, lat, bn);
        tests_run++;
        if (ovf_a !== 1'b1) begin failed++; $display("FAIL ovf_sticky: got %b want 1", ovf_a); end
        run_a(1'b1, 1'b0, 16'd1, 16'd1, lat, bn);
        tests_run++;
        if (acc_a !== 40'd1 || ovf_a !== 1'b0) begin
            failed++; $display("FAIL ovf_clear: got %0d ovf=%b want 1 ovf=0", $signed(acc_a), ovf_a);
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        int first = -1;
        tick();
        clr_a = 1'b1; msub_a = 1'b0; x_a = 16'd6; y_a = 16'd9; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            start_a = (c == 3);
            x_a = 16'd100; y_a = 16'd100; clr_a = 1'b1;
            tick();
            if (done_a) begin
                dones++;
                if (first < 0) first = c;
            end
        end
        start_a = 1'b0;
        tests_run++;
        if (dones !== 1 || first !== 8) begin
            failed++; $display("FAIL start_in_run: dones=%0d first=%0d want dones=1 first=8", dones, first);
        end
        tests_run++;
        if (acc_a !== 40'd54) begin failed++; $display("FAIL start_in_run_acc: got %0d want 54", $signed(acc_a)); end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        clr_a = 1'b0; msub_a = 1'b0; x_a = 16'd10; y_a = 16'd10; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (acc_a !== 40'd0 || busy_a !== 1'b0 || ovf_a !== 1'b0) begin
            failed++; $display("FAIL reset_mid_run: acc=%h busy=%b ovf=%b want 0 0 0", acc_a, busy_a, ovf_a);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done_a || busy_a) dones++;
        end
        tests_run++;
        if (dones !== 0) begin failed++; $display("FAIL reset_no_done: got %0d active cycles want 0", dones); end
    endtask

    task automatic test_reset_and_start();
        int act = 0;
        reset = 1'b1; start_a = 1'b1; clr_a = 1'b0; msub_a = 1'b0; x_a = 16'd2; y_a = 16'd2;
        tick();
        reset = 1'b0; start_a = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (busy_a || done_a) act++;
            tick();
        end
        tests_run++;
        if (act !== 0 || acc_a !== 40'd0) begin
            failed++; $display("FAIL reset_with_start: active=%0d acc=%h want 0 0", act, acc_a);
        end
    endtask

    task automatic test_odd_width();
        int lat = -1;
        clr_b = 1'b1; msub_b = 1'b0; x_b = 5'd15; y_b = 5'b10000; start_b = 1'b1;
        tick();
        start_b = 1'b0; x_b = 5'd3; y_b = 5'd3; clr_b = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done_b) begin lat = c; break; end
        end
        tests_run++;
        if (lat !== 3) begin failed++; $display("FAIL odd_latency: got %0d want 3", lat); end
        tests_run++;
        if (acc_b !== 10'h310) begin failed++; $display("FAIL odd_acc1: got %0d want -240", $signed(acc_b)); end
        clr_b = 1'b0; msub_b = 1'b1; x_b = 5'b10000; y_b = 5'b10000; start_b = 1'b1;
        tick();
        start_b = 1'b0; msub_b = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done_b) begin lat = c; break; end
        end
        tests_run++;
        if (acc_b !== 10'h210 || ovf_b !== 1'b0 || lat !== 3) begin
            failed++; $display("FAIL odd_acc2: got %0d ovf=%b lat=%0d want -496 ovf=0 lat=3", $signed(acc_b), ovf_b, lat);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; msub_a = 1'b0; clr_a = 1'b0; x_a = '0; y_a = '0;
        start_b = 1'b0; msub_b = 1'b0; clr_b = 1'b0; x_b = '0; y_b = '0;
        test_reset();
        test_basic();
        test_msub_back_to_back();
        test_extremes();
        test_overflow();
        test_start_ignored();
        test_reset_mid_run();
        test_reset_and_start();
        test_odd_width();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/booth_seq_mac.md
# booth_seq_mac

Sequential radix-4 Booth multiply-accumulate unit for the EU/MAC datapath. It is the parametrised successor of the combinational Booth digit-select and partial-product-mux pair. One multiplier digit is retired per clock into a wide accumulator, with add or subtract mode, optional accumulator clear, and a sticky overflow flag. It serves low-area DSP configurations where a full array multiplier is not affordable.

## Interface
Parameters:
- WIDTH, 16: operand width; signed two's complement; any value ≥ 2, odd allowed.
- ACC_W, 40: accumulator width; must be ≥ 2*WIDTH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only when the block can accept.
- msub  in  1  1 = accumulator minus product; 0 = accumulator plus product. Latched at accept.
- clr_acc  in  1  1 = accumulate onto zero and clear ovf. Latched at accept.
- x_in  in  WIDTH  multiplicand, signed. Latched at accept.
- y_in  in  WIDTH  multiplier, signed. Latched at accept.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; acc_out holds the final result.
- acc_out  out  ACC_W  accumulator, signed; registered.
- ovf  out  1  sticky signed-overflow flag.

## Operation
- N = ceil(WIDTH/2) digits. y is sign-extended to 2N bits, with implicit y[-1] = 0.
- States:
  - IDLE: start=1 accepts. Go to RUN.
  - RUN: i counts 0..N-1. At i = N-1 the next state is DONE.
  - DONE: done=1. start=1 accepts and goes to RUN. Otherwise go to IDLE.
- Accept actions:
  - Latch x, y, msub and clr_acc.
  - If clr_acc=1: acc = 0 and ovf = 0.
  - Set i = 0.
- Per RUN cycle i:
  - Take the triplet t = {y[2i+1], y[2i], y[2i-1]}.
  - Digit d = -2*t[2] + t[1] + t[0], so d ∈ {-2, -1, 0, +1, +2}.
  - Decode: +1 for t = 001/010, +2 for 011, -1 for 101/110, -2 for 100, 0 for 000/111.
  - msub=1 swaps the plus and minus selects, i.e. negates d.
  - Form the partial product from ±X or ±2X. Sign-extend x to ACC_W, shift left by 2i, then negate for minus selects.
  - acc <= acc + pp, modulo 2^ACC_W; results wrap.
- Overflow: ovf is set when any per-cycle add overflows signed ACC_W (operand signs equal, result sign differs). It stays set until reset or until an accept with clr_acc=1.
- The net effect of one operation is acc ± x*y, exact whenever no overflow occurs.
- Inputs other than start are don't-care outside the accept cycle.
- start in RUN is ignored; it is not queued.
- reset at any time, including mid-RUN:
  - State goes to IDLE.
  - acc_out = 0, ovf = 0, busy = 0, done = 0.
  - No done pulse follows for the aborted operation.
  - reset has priority over start in the same cycle.

## Timing
- Reset values: acc_out = 0, ovf = 0, busy = 0, done = 0, state IDLE.
- Start sampled high at edge E0:
  - busy = 1 after E0.
  - Partial products are added at edges E1..EN.
  - done = 1 and busy = 0 after EN, for one cycle.
- Latency: done appears N cycles after the accept edge. acc_out is final in the done cycle and is held until the next accept.
- Throughput: an accept in the DONE cycle gives back-to-back operations every N+1 cycles.
- acc_out changes only on RUN edges, on a clr_acc accept, or on reset.
- ovf updates on the same edge as the overflowing add.
- acc_out in intermediate RUN cycles is a partial sum. The bench checks it only at done.

## Test plan
- WIDTH=16, ACC_W=40. reset, then start with clr_acc=1, msub=0, x=3, y=5 -> done exactly 8 cycles after the accept edge; acc_out=15; ovf=0; busy high for exactly 8 cycles.
- Following the above: start with clr_acc=0, msub=1, x=-4, y=7 -> acc_out=43 (15 - (-28)). Then an accept in the DONE cycle with clr_acc=0, msub=0, x=-1, y=-1 -> acc_out=44, done pulses 9 cycles after the previous done.
- Extremes: clr_acc=1, x=-32768, y=-32768 -> acc_out=0x0040000000. Also x=32767, y=-32768 with clr_acc=1 -> acc_out=-1073709056.
- Overflow: 512 accumulations of x=y=-32768, the first with clr_acc=1 -> after the 512th, acc_out = -2^39 (0x8000000000) and ovf=1. The next op with clr_acc=1, x=1, y=1 -> acc_out=1, ovf=0.
- Control corners:
  - start pulsed at RUN cycle 3 -> ignored; exactly one done.
  - reset asserted at RUN cycle 4 -> next cycle acc_out=0, busy=0; no done ever follows.
  - reset and start high together -> IDLE, not accepted.
- WIDTH=5, ACC_W=10 instance: clr_acc=1, x=15, y=-16 -> done 3 cycles after accept; acc_out=-240. Then msub=1, x=-16, y=-16 -> acc_out=-496, ovf=0.
